pipelined_cla_adder: RTL

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/cla_pkg.sv | 31 +++
 rtl/pipelined_cla_adder_if.sv | 34 +++
 rtl/cla_group4.sv | 34 +++
 rtl/pipelined_cla_adder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared group width, group propagate/generate pair type and
//                the 4-bit group P/G lookahead function.
//  Revision    : 1.0  initial release
// ============================================================================
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    // Group propagate uses XOR so that P_blk=1 implies G_blk=0.
    function automatic grp_pg_t group_pg(input logic [GROUP_W-1:0] a,
                                         input logic [GROUP_W-1:0] b);
        logic [GROUP_W-1:0] p;
        logic [GROUP_W-1:0] g;
        grp_pg_t            r;
        p   = a ^ b;
        g   = a & b;
        r.p = &p;
        r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder_if
//  Description : Operand/result handshake bundle of the pipelined CLA adder.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             P_blk;
    logic             G_blk;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf, P_blk, G_blk
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf, P_blk, G_blk
    );
endinterface
`default_nettype wire

// File: rtl/cla_group4.sv
`default_nettype none
// ============================================================================
//  Module      : cla_group4
//  Description : 4-bit lookahead group: group P/G and sum for a given carry-in.
//  Revision    : 1.0  initial release
// ============================================================================
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a_i,
    input  logic [GROUP_W-1:0] b_i,
    input  logic               c_i,
    output grp_pg_t            pg_o,
    output logic [GROUP_W-1:0] s_o
);
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_c;

    always_comb begin
        w_p    = a_i ^ b_i;
        w_g    = a_i & b_i;
        w_c[0] = c_i;
        w_c[1] = w_g[0] | (w_p[0] & c_i);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_i);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & c_i);
        s_o    = w_p ^ w_c;
        pg_o.p = &w_p;
        pg_o.g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    end
endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder
//  Description : Two-stage valid/ready carry-lookahead add/subtract unit with
//                two-level group lookahead and block P/G for cascading.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    pipelined_cla_adder_if.slave  bus
);
    localparam int NG = WIDTH / GROUP_W;
    localparam int NS = (NG + 3) / 4;
    localparam int NP = NS * 4;

    logic                v1_q, v1_d, v2_q, v2_d;
    logic [WIDTH-1:0]    a1_q, b1_q;
    logic                cin1_q;
    grp_pg_t [NG-1:0]    pg1_q;
    logic [WIDTH-1:0]    s2_q;
    logic                cout2_q, ovf2_q, pblk2_q, gblk2_q;

    logic                w_s2_take, w_s1_adv, w_accept;
    logic [WIDTH-1:0]    w_b_eff;
    grp_pg_t [NG-1:0]    w_pg_in;
    grp_pg_t [NG-1:0]    w_pg_unused;
    grp_pg_t [NP-1:0]    w_pg_pad;
    logic [NS-1:0]       w_sp, w_sg;
    logic [NS:0]         w_sc;
    logic [NP-1:0]       w_gc;
    logic                w_bg;
    logic [WIDTH-1:0]    w_sum;
    logic                w_ovf;

    assign w_s2_take    = !v2_q || bus.out_ready;
    assign w_s1_adv     = v1_q && w_s2_take;
    assign bus.in_ready = !v1_q || w_s2_take;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_b_eff      = bus.Sub ? ~bus.B : bus.B;

    always_comb begin
        v1_d = v1_q;
        if (w_accept)      v1_d = 1'b1;
        else if (w_s1_adv) v1_d = 1'b0;
        v2_d = w_s2_take ? v1_q : v2_q;
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_pg_in
        assign w_pg_in[gi] = group_pg(bus.A[gi*GROUP_W +: GROUP_W], w_b_eff[gi*GROUP_W +: GROUP_W]);
    end

    // Groups beyond NG pad the last super-group as transparent (P=1, G=0).
    for (genvar gi = 0; gi < NP; gi++) begin : g_pad
        if (gi < NG) begin : g_real
            assign w_pg_pad[gi] = pg1_q[gi];
        end else begin : g_fill
            assign w_pg_pad[gi] = '{p: 1'b1, g: 1'b0};
        end
    end

    always_comb begin
        w_sc[0] = cin1_q;
        w_bg    = 1'b0;
        for (int s = 0; s < NS; s++) begin
            w_sp[s] = 1'b1;
            w_sg[s] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                w_sg[s] = w_pg_pad[4*s+k].g | (w_pg_pad[4*s+k].p & w_sg[s]);
                w_sp[s] = w_sp[s] & w_pg_pad[4*s+k].p;
            end
            w_sc[s+1] = w_sg[s] | (w_sp[s] & w_sc[s]);
            w_bg      = w_sg[s] | (w_sp[s] & w_bg);
            w_gc[4*s] = w_sc[s];
            for (int k = 1; k < 4; k++) begin
                w_gc[4*s+k] = w_pg_pad[4*s+k-1].g | (w_pg_pad[4*s+k-1].p & w_gc[4*s+k-1]);
            end
        end
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group4 u_grp (
            .a_i  (a1_q[gi*GROUP_W +: GROUP_W]),
            .b_i  (b1_q[gi*GROUP_W +: GROUP_W]),
            .c_i  (w_gc[gi]),
            .pg_o (w_pg_unused[gi]),
            .s_o  (w_sum[gi*GROUP_W +: GROUP_W])
        );
    end

    // Carry into the MSB recovered from the MSB sum bit.
    assign w_ovf = (a1_q[WIDTH-1] ^ b1_q[WIDTH-1] ^ w_sum[WIDTH-1]) ^ w_sc[NS];

    always_ff @(posedge Clk) begin
        if (w_accept) begin
            a1_q   <= bus.A;
            b1_q   <= w_b_eff;
            cin1_q <= bus.Sub | bus.Cin;
            pg1_q  <= w_pg_in;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            s2_q    <= '0;
            cout2_q <= 1'b0;
            ovf2_q  <= 1'b0;
            pblk2_q <= 1'b0;
            gblk2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (w_s1_adv) begin
                s2_q    <= w_sum;
                cout2_q <= w_sc[NS];
                ovf2_q  <= w_ovf;
                pblk2_q <= &w_sp;
                gblk2_q <= w_bg;
            end
        end
    end

    assign bus.out_valid = v2_q;
    assign bus.S         = s2_q;
    assign bus.Cout      = cout2_q;
    assign bus.Ovf       = ovf2_q;
    assign bus.P_blk     = pblk2_q;
    assign bus.G_blk     = gblk2_q;
endmodule
`default_nettype wire
